ap_set_arbiter: RTL and testbench
=================================

// Module: ap_set_arbiter
// PURPOSE
//  Shares the 3-bit address-pointer select register (APSel, driven by a 4-bit APSet code:
//  0 = hold, k = select pointer k-1) between NUM_REQ requesters (decoder, DMA, IRQ entry, ...).
//  Round-robin grant with ownership until release, so only one requester drives APSet at a time.
//  Emits a one-cycle APSet pulse per grant, keeps a shadow of APSel and revokes hung owners.
//  Sits between the requesters and the AP select register; its ap_set output feeds APSet directly.
// PARAMETERS
//  NUM_REQ   4     number of requesters, 2..8
//  HOLD_MAX  255   max cycles an owner may stay in OWN before forced revoke; 0 disables watchdog
// PORTS
//  clk            in   1            clock
//  rst            in   1            reset, synchronous, active-high
//  req            in   NUM_REQ      request, level; held until release
//  req_idx        in   3*NUM_REQ    pointer index per requester, slice i = [3*i+2:3*i]
//  rel            in   NUM_REQ      release pulse from owner
//  gnt            out  NUM_REQ      one-hot grant, registered
//  sel_valid      out  1            APSel now holds owner's index; owner may use pointer
//  ap_set         out  4            APSet code to AP select register, 0 except grant pulse
//  ap_sel_shadow  out  3            copy of APSel contents
//  timeout        out  1            one-cycle pulse on watchdog revoke
// BEHAVIOUR
//  Reset: gnt=0, sel_valid=0, ap_set=0, ap_sel_shadow=0 (matches APSel reset), timeout=0,
//   rr_ptr=0, hold_cnt=0, state=IDLE. Reset mid-operation aborts ownership immediately; no ap_set pulse.
//  States: IDLE -> GRANT -> OWN -> (IDLE | GRANT).
//  IDLE: any req -> winner = first set req at or after rr_ptr (wrapping); latch owner, idx=req_idx[owner];
//   go to GRANT. No req -> stay IDLE.
//  GRANT (exactly 1 cycle): gnt[owner]=1, ap_set=idx+1 (4-bit, never 0), ap_sel_shadow<=idx; -> OWN.
//   rel asserted during GRANT is ignored. A changed req_idx after latching is ignored.
//  OWN: gnt[owner]=1, sel_valid=1, ap_set=0, hold_cnt increments each cycle (saturates).
//   Release = rel[owner] | ~req[owner]. rel on non-owner lines is ignored.
//   On release: rr_ptr<=owner+1 mod NUM_REQ; gnt and sel_valid drop next cycle;
//    other req pending (owner excluded) -> GRANT to next winner directly (no IDLE bubble), else IDLE.
//   Watchdog: HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1 with no release -> forced release, timeout=1 one cycle,
//    same next-state rules as normal release.
//  Latency: req in IDLE at cycle N -> ap_set pulse and gnt at N+1 -> APSel updated, sel_valid at N+2.
//  Back-to-back: release in OWN at cycle M -> new grant pulse at M+1.
//  Same index re-requested: pulse still emitted (harmless to APSel); shadow unchanged in value.
//  Arithmetic: ap_set = {1'b0,idx}+4'd1, range 1..8; hold_cnt width clog2(HOLD_MAX+1), saturating.
// STRUCTURE
//  Package ap_arb_pkg: AP_IDX_W=3, APSET_W=4, APSET_NOP=4'd0, state encoding
//   (ST_IDLE, ST_GRANT, ST_OWN), function idx_to_apset.
//  Sub-module rr_pick: combinational round-robin picker (req, rr_ptr, mask -> winner idx, found).
//  Top holds FSM, owner/idx/rr_ptr regs, hold counter, output registers.
// TESTING
//  Reset: rst=1 two cycles with req=all ones -> all outputs 0, no ap_set pulse; first grant goes to req0.
//  Single: req[2]=1, req_idx[2]=5 at N -> gnt=0100 and ap_set=6 at N+1, sel_valid=1 and shadow=5 at N+2.
//  Round robin: req=1111 constant, owner releases after 3 OWN cycles -> grants 0,1,2,3,0; no IDLE cycle between.
//  Release in GRANT: rel[owner] in GRANT cycle -> ignored, OWN entered; rel in OWN then releases.
//  Watchdog: HOLD_MAX=4, owner never releases -> timeout pulse after 4 OWN cycles, gnt drops, next req granted.
//  Mid-op reset: rst during OWN -> next cycle gnt=0, sel_valid=0, shadow=0, rr_ptr=0.

Source files
------------

// File: rtl/ap_arb_pkg.sv
// Shared constants, state encoding and APSet helper for the address-pointer select arbiter.
package ap_arb_pkg;

    localparam int AP_IDX_W = 3;
    localparam int APSET_W  = 4;
    localparam logic [APSET_W-1:0] APSET_NOP = 4'd0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_OWN   = 2'd2;

    // APSet code k selects pointer k-1, so the code is never the hold value 0.
    function automatic logic [APSET_W-1:0] idx_to_apset(input logic [AP_IDX_W-1:0] idx);
        return {1'b0, idx} + 4'd1;
    endfunction

endpackage

// File: rtl/ap_set_arbiter_rr_pick.sv
// Combinational round-robin picker: first set (req & mask) bit at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int OW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OW-1:0]      rr_ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic [OW-1:0]      winner,
    output logic               found
);

    logic [NUM_REQ-1:0] cand;
    logic [OW-1:0]      pos_idx;
    int                 pos;

    assign cand = req & mask;

    always_comb begin
        winner  = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            pos_idx = OW'(pos);
            if (!found && cand[pos_idx]) begin
                found  = 1'b1;
                winner = pos_idx;
            end
        end
    end

endmodule

// File: rtl/ap_set_arbiter.sv
// Round-robin owner arbiter for the APSel register: one APSet pulse per grant,
// ownership until release, APSel shadow copy and a hung-owner watchdog.
module ap_set_arbiter
    import ap_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [AP_IDX_W*NUM_REQ-1:0]  req_idx,
    input  logic [NUM_REQ-1:0]           rel,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         sel_valid,
    output logic [APSET_W-1:0]           ap_set,
    output logic [AP_IDX_W-1:0]          ap_sel_shadow,
    output logic                         timeout
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

    logic [1:0]          state;
    logic [OW-1:0]       owner;
    logic [AP_IDX_W-1:0] idx;
    logic [OW-1:0]       rr_ptr;
    logic [HW-1:0]       hold_cnt;

    logic [OW-1:0]       owner_next;
    logic [NUM_REQ-1:0]  owner_oh;
    logic [OW-1:0]       pick_ptr;
    logic [NUM_REQ-1:0]  pick_mask;
    logic [OW-1:0]       win;
    logic                found;
    logic [NUM_REQ-1:0]  win_oh;
    logic [AP_IDX_W-1:0] win_idx;
    logic                release_req;
    logic                wd_fire;

    assign owner_next = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
    assign owner_oh   = NUM_REQ'(1) << owner;
    assign win_oh     = NUM_REQ'(1) << win;
    assign win_idx    = req_idx[int'(win)*AP_IDX_W +: AP_IDX_W];

    // While owning, the next winner is searched from where rr_ptr will land, excluding the owner,
    // so a handover can go straight to GRANT without an IDLE bubble.
    assign pick_ptr  = (state == ST_OWN) ? owner_next : rr_ptr;
    assign pick_mask = (state == ST_OWN) ? ~owner_oh : '1;

    assign release_req = rel[owner] | ~req[owner];
    assign wd_fire     = (HOLD_MAX != 0) && (hold_cnt == HW'(HOLD_MAX - 1)) && !release_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_pick (
        .req     (req),
        .rr_ptr  (pick_ptr),
        .mask    (pick_mask),
        .winner  (win),
        .found   (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            hold_cnt      <= '0;
            gnt           <= '0;
            sel_valid     <= 1'b0;
            ap_set        <= APSET_NOP;
            ap_sel_shadow <= '0;
            timeout       <= 1'b0;
        end else begin
            ap_set  <= APSET_NOP;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        owner  <= win;
                        idx    <= win_idx;
                        gnt    <= win_oh;
                        ap_set <= idx_to_apset(win_idx);
                        state  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    ap_sel_shadow <= idx;
                    sel_valid     <= 1'b1;
                    hold_cnt      <= '0;
                    state         <= ST_OWN;
                end
                ST_OWN: begin
                    if (release_req || wd_fire) begin
                        rr_ptr    <= owner_next;
                        sel_valid <= 1'b0;
                        timeout   <= wd_fire;
                        if (found) begin
                            owner  <= win;
                            idx    <= win_idx;
                            gnt    <= win_oh;
                            ap_set <= idx_to_apset(win_idx);
                            state  <= ST_GRANT;
                        end else begin
                            gnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end else if (hold_cnt != HW'(HOLD_MAX)) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    gnt       <= '0;
                    sel_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ap_set_arbiter.sv
// Scoreboard bench for ap_set_arbiter: stimulus queues expected grants/timeouts, a monitor checks them.
module tb_ap_set_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] req_idx;
    logic [3:0]  rel;
    logic [3:0]  gnt;
    logic        sel_valid;
    logic [3:0]  ap_set;
    logic [2:0]  ap_sel_shadow;
    logic        timeout;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] apset;
        logic [2:0] shadow;
    } exp_t;

    exp_t       gq[$];
    logic [3:0] tq[$];
    int n_tests = 0;
    int n_fail  = 0;

    ap_set_arbiter #(.NUM_REQ(4), .HOLD_MAX(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_idx       (req_idx),
        .rel           (rel),
        .gnt           (gnt),
        .sel_valid     (sel_valid),
        .ap_set        (ap_set),
        .ap_sel_shadow (ap_sel_shadow),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_gnt"}, 32'(gnt), 32'h0);
        chk({name, "_selv"}, 32'(sel_valid), 32'h0);
        chk({name, "_apset"}, 32'(ap_set), 32'h0);
        chk({name, "_shadow"}, 32'(ap_sel_shadow), 32'h0);
        chk({name, "_tmo"}, 32'(timeout), 32'h0);
    endtask

    // Monitor: each APSet pulse pops a grant record; the following cycle must show the shadow.
    initial begin : monitor
        exp_t e;
        logic pend;
        logic [2:0] pend_shadow;
        logic [3:0] tg;
        pend = 1'b0;
        pend_shadow = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pend) begin
                    chk("mon_selv", 32'(sel_valid), 32'h1);
                    chk("mon_shadow", 32'(ap_sel_shadow), 32'(pend_shadow));
                    pend = 1'b0;
                end
                if (ap_set != 4'd0) begin
                    if (gq.size() == 0) begin
                        chk("mon_unexpected_pulse", 32'(ap_set), 32'h0);
                    end else begin
                        e = gq.pop_front();
                        chk("mon_gnt", 32'(gnt), 32'(e.gnt));
                        chk("mon_apset", 32'(ap_set), 32'(e.apset));
                        pend = 1'b1;
                        pend_shadow = e.shadow;
                    end
                end
                if (timeout) begin
                    if (tq.size() == 0) begin
                        chk("mon_unexpected_timeout", 32'(timeout), 32'h0);
                    end else begin
                        tg = tq.pop_front();
                        chk("mon_tmo_gnt", 32'(gnt), 32'(tg));
                    end
                end
            end
        end
    end

    initial begin : guard
        #100000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench did not finish");
    end

    initial begin : stim
        // idx per requester: r0=2, r1=0, r2=5, r3=7
        req_idx = {3'd7, 3'd5, 3'd0, 3'd2};
        rel = 4'b0000;

        // Reset with all requests up
        rst = 1'b1;
        req = 4'b1111;
        step();
        chk_idle("rst1");
        step();
        chk_idle("rst2");
        rst = 1'b0;
        gq.push_back('{gnt: 4'b0001, apset: 4'd3, shadow: 3'd2});
        step();
        chk("first_gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        step();
        chk("first_rel_gnt", 32'(gnt), 32'h0);

        // Single request, latency check
        req = 4'b0100;
        gq.push_back('{gnt: 4'b0100, apset: 4'd6, shadow: 3'd5});
        step();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_apset", 32'(ap_set), 32'h6);
        chk("single_selv_early", 32'(sel_valid), 32'h0);
        step();
        chk("single_selv", 32'(sel_valid), 32'h1);
        chk("single_shadow", 32'(ap_sel_shadow), 32'h5);
        chk("single_apset_nop", 32'(ap_set), 32'h0);
        req = 4'b0000;
        step();
        chk("single_rel_gnt", 32'(gnt), 32'h0);
        chk("single_rel_selv", 32'(sel_valid), 32'h0);

        // Mid-operation reset while r3 owns
        req = 4'b1000;
        gq.push_back('{gnt: 4'b1000, apset: 4'd8, shadow: 3'd7});
        step();
        step();
        step();
        chk("midrst_own_shadow", 32'(ap_sel_shadow), 32'h7);
        rst = 1'b1;
        step();
        chk_idle("midrst");

        // Round robin from rr_ptr=0, constant requests, release on 3rd OWN cycle
        rst = 1'b0;
        req = 4'b1111;
        gq.push_back('{gnt: 4'b0001, apset: 4'd3, shadow: 3'd2});
        gq.push_back('{gnt: 4'b0010, apset: 4'd1, shadow: 3'd0});
        gq.push_back('{gnt: 4'b0100, apset: 4'd6, shadow: 3'd5});
        gq.push_back('{gnt: 4'b1000, apset: 4'd8, shadow: 3'd7});
        gq.push_back('{gnt: 4'b0001, apset: 4'd3, shadow: 3'd2});
        step();
        chk("rr_first_gnt", 32'(gnt), 32'h1);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] own_oh;
            logic [3:0] nxt_oh;
            own_oh = 4'b0001 << k;
            nxt_oh = 4'b0001 << ((k + 1) % 4);
            step();
            rel = nxt_oh;
            step();
            rel = 4'b0000;
            step();
            rel = own_oh;
            step();
            rel = 4'b0000;
            chk("rr_handover_gnt", 32'(gnt), 32'(nxt_oh));
        end
        req = 4'b0000;
        step();
        step();
        chk("rr_end_gnt", 32'(gnt), 32'h0);

        // rel during GRANT is ignored (rr_ptr=1 now)
        req = 4'b0100;
        gq.push_back('{gnt: 4'b0100, apset: 4'd6, shadow: 3'd5});
        step();
        rel = 4'b0100;
        step();
        rel = 4'b0000;
        chk("relg_own_gnt", 32'(gnt), 32'h4);
        chk("relg_own_selv", 32'(sel_valid), 32'h1);
        step();
        chk("relg_still_own", 32'(gnt), 32'h4);
        rel = 4'b0100;
        req = 4'b0000;
        step();
        rel = 4'b0000;
        chk("relg_rel_gnt", 32'(gnt), 32'h0);
        chk("relg_rel_selv", 32'(sel_valid), 32'h0);

        // Watchdog: rr_ptr=3, r3 and r0 never release
        req = 4'b1001;
        gq.push_back('{gnt: 4'b1000, apset: 4'd8, shadow: 3'd7});
        gq.push_back('{gnt: 4'b0001, apset: 4'd3, shadow: 3'd2});
        tq.push_back(4'b0001);
        step();
        chk("wd_gnt", 32'(gnt), 32'h8);
        step();
        step();
        step();
        step();
        chk("wd_tmo_before", 32'(timeout), 32'h0);
        chk("wd_gnt_before", 32'(gnt), 32'h8);
        step();
        chk("wd_tmo", 32'(timeout), 32'h1);
        chk("wd_next_gnt", 32'(gnt), 32'h1);
        chk("wd_next_apset", 32'(ap_set), 32'h3);
        req = 4'b0000;
        step();
        chk("wd_tmo_pulse", 32'(timeout), 32'h0);
        step();
        chk("wd_end_gnt", 32'(gnt), 32'h0);

        step();
        step();
        chk("sb_grants_drained", 32'(gq.size()), 32'h0);
        chk("sb_timeouts_drained", 32'(tq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
